// File: rtl/constants.sv
// ============================================================================
// Module  : constants
// Brief   : Shared LBIST constants, including signature-unload frame helpers.
//           Config macro: SIG_UNLOAD_PARITY_EN appends an even-parity frame bit.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package constants;

  localparam int n_misr = 64;

  localparam logic [3:0] SIG_HDR = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOADED = 2'd1,
    S_SEND   = 2'd2,
    S_DONE   = 2'd3
  } sig_unload_state_t;

`ifdef SIG_UNLOAD_PARITY_EN
  localparam int SIG_PARITY_BITS = 1;
`else
  localparam int SIG_PARITY_BITS = 0;
`endif

  // Header (4) + verdict (1) + signature (n) + optional parity.
  function automatic int sig_frame_len(input int n);
    return n + 5 + SIG_PARITY_BITS;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sig_piso.sv
// ============================================================================
// Module  : sig_piso
// Brief   : Parallel-load, shift-left register exposing its MSB.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sig_piso #(
  parameter int W = 69
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_data[W-1];

endmodule

`default_nettype wire

// File: rtl/sig_unload.sv
// ============================================================================
// Module  : sig_unload
// Brief   : Snapshots MISR signature + verdict and unloads them as a framed,
//           MSB-first serial stream. Config macro: SIG_UNLOAD_PARITY_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module sig_unload
  import constants::*;
#(
  parameter int N = n_misr
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         CAPTURE,
  input  logic [N-1:0] SIGNATURE,
  input  logic         PASS,
  input  logic         UNLOAD_REQ,
  input  logic         SDO_READY,
  output logic         SDO,
  output logic         SDO_VALID,
  output logic         BUSY,
  output logic         LOADED,
  output logic         DONE,
  output logic         OVERRUN
);

  localparam int FRAME_LEN = sig_frame_len(N);
  localparam int CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] C_LAST = CW'(FRAME_LEN - 1);

  sig_unload_state_t r_state;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_snap_sig;
  logic              r_snap_pass;
  logic              r_valid;
  logic              r_busy;
  logic              r_loaded;
  logic              r_done;
  logic              r_overrun;

  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_start;
  logic                 w_xfer;
  logic                 w_msb;

`ifdef SIG_UNLOAD_PARITY_EN
  assign w_frame = {SIG_HDR, r_snap_pass, r_snap_sig, ^{r_snap_pass, r_snap_sig}};
`else
  assign w_frame = {SIG_HDR, r_snap_pass, r_snap_sig};
`endif

  // A capture in S_LOADED wins over a simultaneous unload request.
  assign w_start = (r_state == S_LOADED) && !CAPTURE && UNLOAD_REQ;
  assign w_xfer  = r_valid && SDO_READY;

  sig_piso #(.W(FRAME_LEN)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_start),
    .i_shift (w_xfer),
    .i_data  (w_frame),
    .o_msb   (w_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_snap_sig  <= '0;
      r_snap_pass <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_loaded    <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // The snapshot stays frozen while a frame is on the wire.
      if (CAPTURE) begin
        if (r_state == S_SEND) begin
          r_overrun <= 1'b1;
        end else begin
          r_snap_sig  <= SIGNATURE;
          r_snap_pass <= PASS;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (CAPTURE) begin
            r_state  <= S_LOADED;
            r_loaded <= 1'b1;
          end
        end
        S_LOADED: begin
          if (w_start) begin
            r_state <= S_SEND;
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_cnt == C_LAST) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_LOADED;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign SDO       = r_valid & w_msb;
  assign SDO_VALID = r_valid;
  assign BUSY      = r_busy;
  assign LOADED    = r_loaded;
  assign DONE      = r_done;
  assign OVERRUN   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sig_unload.sv
// ============================================================================
// Module  : tb_sig_unload
// Brief   : Self-checking bench for sig_unload (vector table + random frames).
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sig_unload;

  localparam int N = 64;
`ifdef SIG_UNLOAD_PARITY_EN
  localparam int FL = N + 6;
`else
  localparam int FL = N + 5;
`endif
  localparam logic [N-1:0] S1 = 64'hEFCF01E7782667FA;

  logic         clk = 1'b0;
  logic         rst;
  logic         CAPTURE;
  logic [N-1:0] SIGNATURE;
  logic         PASS;
  logic         UNLOAD_REQ;
  logic         SDO_READY;
  logic         SDO;
  logic         SDO_VALID;
  logic         BUSY;
  logic         LOADED;
  logic         DONE;
  logic         OVERRUN;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sig_unload #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .CAPTURE    (CAPTURE),
    .SIGNATURE  (SIGNATURE),
    .PASS       (PASS),
    .UNLOAD_REQ (UNLOAD_REQ),
    .SDO_READY  (SDO_READY),
    .SDO        (SDO),
    .SDO_VALID  (SDO_VALID),
    .BUSY       (BUSY),
    .LOADED     (LOADED),
    .DONE       (DONE),
    .OVERRUN    (OVERRUN)
  );

  typedef struct {
    string        name;
    logic         cap;
    logic         pass;
    logic [N-1:0] sig;
    logic         req;
    logic         ready;
    logic         e_valid;
    logic         e_busy;
    logic         e_loaded;
    logic         e_done;
    logic         e_sdo;
  } vec_t;

  vec_t vecs [8];
  logic exp_bits [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference frame: header, verdict, signature MSB first, optional even parity.
  task automatic build_frame(input logic [N-1:0] sig, input logic pass);
    logic [3:0] hdr;
    int ones;
    hdr = 4'b1010;
    exp_bits = {};
    for (int i = 3; i >= 0; i--) exp_bits.push_back(hdr[i]);
    exp_bits.push_back(pass);
    for (int i = N - 1; i >= 0; i--) exp_bits.push_back(sig[i]);
    ones = $countones({pass, sig});
    if (FL == N + 6) exp_bits.push_back((ones % 2) == 1);
  endtask

  // mode 0: ready high, 1: ready every other cycle, 2: random ready.
  task automatic run_frame(input logic [N-1:0] sig, input logic pass, input int mode,
                           input int skip, input int cap_at, input int abort_at);
    int   idx;
    int   cyc;
    int   vcyc;
    bit   stalled;
    bit   fin;
    logic held;
    idx = skip; cyc = 0; vcyc = 0; stalled = 0; fin = 0; held = 1'b0;
    build_frame(sig, pass);
    while (!fin) begin
      CAPTURE = 1'b0;
      if (DONE) begin
        chk("frame_bits", idx, FL);
        if (skip == 0 && mode == 0) chk("span_ready_high", vcyc, FL);
        if (skip == 0 && mode == 1) chk("span_toggle", vcyc, 2 * FL);
        chk("busy_low_at_done", BUSY, 0);
        fin = 1;
      end else if (cyc > 1000) begin
        total++;
        bad++;
        $display("FAIL frame_timeout: got %0d bits expected %0d", idx, FL);
        fin = 1;
      end else if (SDO_VALID && abort_at == idx) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", SDO_VALID, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_loaded", LOADED, 0);
        chk("abort_overrun", OVERRUN, 0);
        fin = 1;
      end else begin
        if (SDO_VALID) begin
          vcyc++;
          chk("busy_in_frame", BUSY, 1);
          if (stalled) chk("stall_hold", SDO, held);
          case (mode)
            0:       SDO_READY = 1'b1;
            1:       SDO_READY = (vcyc % 2) == 0;
            default: SDO_READY = 1'($urandom_range(0, 1));
          endcase
          if (SDO_READY) begin
            if (cap_at == idx) begin
              CAPTURE   = 1'b1;
              SIGNATURE = '0;
            end
            chk("sdo_bit", SDO, (idx < FL) ? exp_bits[idx] : 1'bx);
            idx++;
            stalled = 0;
          end else begin
            stalled = 1;
            held    = SDO;
          end
        end else begin
          chk("sdo_zero_when_idle", SDO, 0);
          SDO_READY = 1'b0;
        end
        tick();
        cyc++;
      end
    end
    SDO_READY = 1'b0;
    CAPTURE   = 1'b0;
  endtask

  task automatic start_unload();
    UNLOAD_REQ = 1'b1;
    tick();
    UNLOAD_REQ = 1'b0;
    chk("start_valid", SDO_VALID, 1);
    chk("start_sdo_hdr", SDO, 1);
  endtask

  task automatic after_done();
    tick();
    chk("done_one_cycle", DONE, 0);
    chk("loaded_after_done", LOADED, 1);
    chk("valid_after_done", SDO_VALID, 0);
  endtask

  task automatic do_capture(input logic [N-1:0] sig, input logic pass);
    CAPTURE   = 1'b1;
    SIGNATURE = sig;
    PASS      = pass;
    tick();
    CAPTURE   = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rsig;
    logic         rpass;

    vecs[0] = '{"idle_req_ignored", 0, 0, S1, 1, 1, 0, 0, 0, 0, 0};
    vecs[1] = '{"capture",          1, 1, S1, 0, 0, 0, 0, 1, 0, 0};
    vecs[2] = '{"unload_start",     0, 1, S1, 1, 0, 1, 1, 1, 0, 1};
    vecs[3] = '{"stall_bit0",       0, 1, S1, 0, 0, 1, 1, 1, 0, 1};
    vecs[4] = '{"shift_bit1",       0, 1, S1, 0, 1, 1, 1, 1, 0, 0};
    vecs[5] = '{"shift_bit2",       0, 1, S1, 0, 1, 1, 1, 1, 0, 1};
    vecs[6] = '{"stall_bit2",       0, 1, S1, 0, 0, 1, 1, 1, 0, 1};
    vecs[7] = '{"shift_bit3",       0, 1, S1, 0, 1, 1, 1, 1, 0, 0};

    rst = 1'b1; CAPTURE = 1'b0; PASS = 1'b0; UNLOAD_REQ = 1'b0;
    SDO_READY = 1'b0; SIGNATURE = '0;
    tick();
    tick();
    chk("rst_sdo", SDO, 0);
    chk("rst_valid", SDO_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_loaded", LOADED, 0);
    chk("rst_done", DONE, 0);
    chk("rst_overrun", OVERRUN, 0);
    rst = 1'b0;
    tick();

    // Basic unload: first bits from the table, remainder with ready high.
    for (int i = 0; i < 8; i++) begin
      CAPTURE = vecs[i].cap; PASS = vecs[i].pass; SIGNATURE = vecs[i].sig;
      UNLOAD_REQ = vecs[i].req; SDO_READY = vecs[i].ready;
      tick();
      chk({vecs[i].name, "_valid"},  SDO_VALID, vecs[i].e_valid);
      chk({vecs[i].name, "_busy"},   BUSY,      vecs[i].e_busy);
      chk({vecs[i].name, "_loaded"}, LOADED,    vecs[i].e_loaded);
      chk({vecs[i].name, "_done"},   DONE,      vecs[i].e_done);
      chk({vecs[i].name, "_sdo"},    SDO,       vecs[i].e_sdo);
    end
    CAPTURE = 1'b0; UNLOAD_REQ = 1'b0;
    run_frame(S1, 1'b1, 0, 3, -1, -1);
    after_done();

    // Re-send without capture, then backpressure.
    start_unload();
    run_frame(S1, 1'b1, 0, 0, -1, -1);
    after_done();
    start_unload();
    run_frame(S1, 1'b1, 1, 0, -1, -1);
    after_done();

    // Random snapshots with random ready.
    for (int k = 0; k < 4; k++) begin
      rsig  = {$urandom, $urandom};
      rpass = 1'($urandom_range(0, 1));
      do_capture(rsig, rpass);
      chk("rand_loaded", LOADED, 1);
      start_unload();
      run_frame(rsig, rpass, 2, 0, -1, -1);
      after_done();
    end

    // Overrun: capture mid-frame is dropped and flagged.
    chk("overrun_clear", OVERRUN, 0);
    do_capture(S1, 1'b1);
    start_unload();
    run_frame(S1, 1'b1, 0, 0, 20, -1);
    after_done();
    chk("overrun_set", OVERRUN, 1);
    start_unload();
    run_frame(S1, 1'b1, 0, 0, -1, -1);
    after_done();
    chk("overrun_sticky", OVERRUN, 1);

    // Simultaneous capture and request in S_LOADED.
    CAPTURE = 1'b1; SIGNATURE = 64'h1; PASS = 1'b0; UNLOAD_REQ = 1'b1;
    tick();
    chk("simul_valid", SDO_VALID, 0);
    chk("simul_loaded", LOADED, 1);
    CAPTURE = 1'b0;
    tick();
    chk("simul_start", SDO_VALID, 1);
    UNLOAD_REQ = 1'b0;
    run_frame(64'h1, 1'b0, 0, 0, -1, -1);
    after_done();

    // Reset mid-frame, then a request with no snapshot.
    start_unload();
    run_frame(64'h1, 1'b0, 0, 0, -1, 30);
    @(negedge clk);
    rst = 1'b0;
    tick();
    UNLOAD_REQ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_valid", SDO_VALID, 0);
      chk("post_rst_no_loaded", LOADED, 0);
    end
    UNLOAD_REQ = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sig_unload.md
# sig_unload

Serial signature unload port for the LBIST subsystem. It snapshots the MISR signature and the controller's pass/fail verdict at end of test. It then transmits them to an external tester as one framed, MSB-first bitstream under a valid/ready handshake. It sits beside `controller` and `MISR` and is the read-out end of the compaction path, so a tester can retrieve the raw signature instead of trusting only the on-chip golden compare.

## Interface
- `N`, 64: signature width; must equal `n_misr`.
- `clk`  in  1: clock.
- `rst`  in  1: reset; asynchronous, active-high. All state clears immediately on assertion.
- `CAPTURE`  in  1: single-cycle pulse from the controller at end of test; latches `SIGNATURE` and `PASS`.
- `SIGNATURE`  in  N: MISR signature.
- `PASS`  in  1: controller verdict, 1 = signature matched golden.
- `UNLOAD_REQ`  in  1: tester requests transmission of the held snapshot (level).
- `SDO_READY`  in  1: tester accepts the current bit.
- `SDO`  out  1: serial data bit.
- `SDO_VALID`  out  1: `SDO` holds a frame bit.
- `BUSY`  out  1: frame transmission in progress.
- `LOADED`  out  1: a snapshot is held.
- `DONE`  out  1: one-cycle pulse after the last frame bit transfers.
- `OVERRUN`  out  1: sticky; a `CAPTURE` arrived while `BUSY` was high.

## Operation
- Frame, sent MSB first:
  - header 4'b1010;
  - `PASS`;
  - `SIGNATURE[N-1:0]`;
  - optional parity bit (see Configuration).
- FRAME_LEN = N+5, or N+6 with parity.
- States:
  - **S_IDLE**: no snapshot.
    - On `CAPTURE`: latch the snapshot register, go to S_LOADED.
    - `UNLOAD_REQ` is ignored.
  - **S_LOADED**:
    - On `CAPTURE`: overwrite the snapshot and stay in S_LOADED. `CAPTURE` takes priority over a simultaneous `UNLOAD_REQ`; the request is serviced next cycle with the new data if still high.
    - Otherwise, on `UNLOAD_REQ`: copy the frame into the PISO shift register, clear the bit counter, go to S_SEND.
  - **S_SEND**:
    - `SDO_VALID`=1 and `SDO`=PISO MSB.
    - On each cycle with `SDO_VALID`&`SDO_READY`: shift left and increment the counter.
    - On the handshake with counter = FRAME_LEN-1: go to S_DONE.
    - Deasserting `UNLOAD_REQ` mid-frame has no effect; the frame always completes.
    - A `CAPTURE` here is dropped (snapshot unchanged) and sets `OVERRUN`.
  - **S_DONE**: `DONE`=1 for exactly one cycle, then go to S_LOADED. The snapshot is retained, so a new `UNLOAD_REQ` re-sends the identical frame.
- `SDO` is 0 whenever `SDO_VALID`=0.
- `OVERRUN` clears only on `rst`.
- The snapshot register and the PISO register are separate, so re-sends need no recapture.

## Timing
- Reset values:
  - state S_IDLE;
  - `SDO`=0, `SDO_VALID`=0, `BUSY`=0, `LOADED`=0, `DONE`=0, `OVERRUN`=0;
  - snapshot, PISO and counter all zero.
- `CAPTURE` sampled at edge k: `LOADED`=1 from edge k.
- `UNLOAD_REQ` sampled at edge k while in S_LOADED: `SDO_VALID`=`BUSY`=1 from edge k, carrying the first header bit (1).
- Outputs decode directly from state/registers; there are no combinational paths from inputs to outputs.
- With `SDO_READY` held high, the frame takes FRAME_LEN cycles. `DONE` is high in the cycle after the last handshake; `BUSY` falls on that same edge.
- Stalls of any length hold `SDO` stable.
- Counter width is $clog2(FRAME_LEN). The counter never wraps, because the state exits at FRAME_LEN-1.
- `rst` mid-frame aborts immediately: `SDO_VALID` drops asynchronously and the snapshot is lost.

## Configuration
- `SIG_UNLOAD_PARITY_EN` defined:
  - frame gains a trailing bit equal to ^{PASS, SIGNATURE}, i.e. even parity over the verdict and signature bits;
  - FRAME_LEN = N+6.
- Macro undefined:
  - no parity bit is built;
  - FRAME_LEN = N+5.

## Structure
- Package `constants` gains:
  - `SIG_HDR` = 4'b1010;
  - `sig_unload_state_t` enum {S_IDLE, S_LOADED, S_SEND, S_DONE};
  - the FRAME_LEN localparam derivation.
- The existing `n_misr` constant sizes `N`.
- One sub-module, `sig_piso`: a parallel-load, shift-left register with load/shift enables and a MSB output. The FSM, counter and snapshot stay in `sig_unload`.

## Test plan
1. **Basic unload**: `rst` pulse, then `CAPTURE` with `SIGNATURE`=64'hEFCF01E7782667FA, `PASS`=1, then `UNLOAD_REQ`=1 and `SDO_READY`=1 → bits 1,0,1,0,1 followed by 1110_1111_1100_1111…1111_1010. Without the macro: 69 transfers, then a `DONE` pulse. With the macro: a 70th bit = 1 (38 ones + `PASS` = odd, so parity 1).
2. **Backpressure**: same frame with `SDO_READY` toggling every other cycle → identical bit sequence, `SDO` stable during stalls, frame spans 138 cycles.
3. **Re-send**: after `DONE`, assert `UNLOAD_REQ` again with no `CAPTURE` → identical frame.
4. **Overrun**: `CAPTURE` with 64'h0 at bit 20 of a frame → frame unchanged, `OVERRUN`=1 and held until `rst`.
5. **Simultaneous events**: `CAPTURE` (`SIGNATURE`=64'h1, `PASS`=0) and `UNLOAD_REQ` in the same cycle while in S_LOADED → stays S_LOADED one cycle, then the frame carries header, 0, 63 zeros, 1.
6. **Reset mid-frame**: assert `rst` at bit 30 → `SDO_VALID`, `BUSY`, `LOADED` all 0 immediately. A subsequent `UNLOAD_REQ` without `CAPTURE` produces no transfer.
